// File: rtl/dds_wave_gen.sv
// Direct-digital-synthesis sample source for the DAC SPI stage.
// A phase accumulator advances once per sample period. The phase is turned
// into a 10-bit offset-binary sample: sine (from a quarter-wave ROM), saw,
// triangle or square. The sample is packed into the DAC command word and
// announced with a one-cycle start pulse.
module dds_wave_gen #(
    parameter int         CLK_FREQ = 12_000_000,
    parameter int         F_SAMPLE = 100_000,
    parameter int         PHASE_W  = 32,
    parameter int         LUT_AW   = 8,
    parameter logic [3:0] DAC_CTRL = 4'b0001
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PHASE_W-1:0] tune_word,
    input  logic               tune_load,
    input  logic [1:0]         wave_sel,
    input  logic               phase_clr,
    input  logic               spi_busy,
    output logic               start,
    output logic [15:0]        data,
    output logic [9:0]         sample,
    output logic               overrun
);

    localparam int DIV     = CLK_FREQ / F_SAMPLE;
    localparam int DIV_W   = $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam int DATA_W  = 10;
    localparam int COEF_W  = 9;
    localparam int LUT_N   = 1 << LUT_AW;
    // Top phase bits carried down the pipe: saw and triangle need 11 bits,
    // and the ROM index (LUT_AW <= 9) sits inside the same window.
    localparam int TOP_W   = 11;
    localparam int FX_W    = 28;
    localparam longint PI_FX = 64'sd843314857;   // pi * 2^28
    localparam logic [15:0] DATA_RST = {DAC_CTRL, 10'd512, 2'b00};

    // ROM entry i = round(511 * sin(pi/2 * (i + 0.5) / LUT_N)).
    // Integer Taylor series in Q28, evaluated at elaboration only.
    function automatic logic [COEF_W-1:0] lut_entry(input int i);
        longint x;
        longint x2;
        longint term;
        longint acc;
        x    = (PI_FX * longint'(2 * i + 1)) / longint'(4 * LUT_N);
        x2   = (x * x) >>> FX_W;
        term = x;
        acc  = x;
        for (int k = 1; k <= 7; k++) begin
            term = -((term * x2) >>> FX_W) / longint'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        return COEF_W'((longint'(2 ** COEF_W - 1) * acc + (longint'(1) <<< (FX_W - 1))) >>> FX_W);
    endfunction

    // Clamp a signed intermediate into the unsigned 10-bit DAC range.
    function automatic logic [DATA_W-1:0] sat_u10(input logic signed [11:0] v);
        logic [DATA_W-1:0] r;
        if (v < 12'sd0)
            r = '0;
        else if (v > 12'sd1023)
            r = 10'd1023;
        else
            r = v[DATA_W-1:0];
        return r;
    endfunction

    // Mirror the quarter-wave magnitude around mid-scale by half-cycle.
    function automatic logic [DATA_W-1:0] sine_sample(input logic [1:0] q,
                                                       input logic [COEF_W-1:0] mag);
        logic signed [11:0] mid;
        logic signed [11:0] m;
        mid = 12'sd512;
        m   = $signed(12'(mag));
        return sat_u10(q[1] ? (mid - m) : (mid + m));
    endfunction

    function automatic logic [DATA_W-1:0] wave_sample(input logic [1:0] sel,
                                                      input logic [TOP_W-1:0] top,
                                                      input logic [COEF_W-1:0] mag);
        logic [DATA_W-1:0] tri_v;
        logic [DATA_W-1:0] res;
        tri_v = top[TOP_W-2 -: DATA_W];
        if (top[TOP_W-1])
            tri_v = ~tri_v;
        case (sel)
            2'd0:    res = sine_sample(top[TOP_W-1 -: 2], mag);
            2'd1:    res = top[TOP_W-1 -: DATA_W];
            2'd2:    res = tri_v;
            default: res = top[TOP_W-1] ? 10'd0 : 10'd1023;
        endcase
        return res;
    endfunction

    logic [COEF_W-1:0] lut_rom [LUT_N];

    for (genvar g = 0; g < LUT_N; g++) begin : g_lut
        localparam logic [COEF_W-1:0] ENTRY = lut_entry(g);
        assign lut_rom[g] = ENTRY;
    end

    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] tune_active;

    assign tick = en && (div_cnt == DIV_LAST);

    // Sample-period divider; parked at zero while disabled.
    always_ff @(posedge clk) begin
        if (rst || !en)
            div_cnt <= '0;
        else if (div_cnt == DIV_LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DIV_W'(1);
    end

    // Tuning register and phase accumulator; phase_clr overrides the step.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= '0;
            tune_active <= '0;
        end else begin
            if (tune_load)
                tune_active <= tune_word;
            if (phase_clr)
                phase <= '0;
            else if (tick)
                phase <= phase + tune_active;
        end
    end

    // ---- stage 1: capture pre-update phase and waveform select ----
    logic             vld_p1;
    logic [TOP_W-1:0] top_p1;
    logic [1:0]       sel_p1;
    logic [1:0]       quad_p1;
    logic [LUT_AW-1:0] idx_p1;
    logic [LUT_AW-1:0] addr_p1;

    // Stage-1 valid follows the sample tick.
    always_ff @(posedge clk) begin
        if (rst)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= tick;
    end

    // Stage-1 data registers load only on a tick.
    always_ff @(posedge clk) begin
        if (tick) begin
            top_p1 <= phase[PHASE_W-1 -: TOP_W];
            sel_p1 <= wave_sel;
        end
    end

    // Quadrants 1 and 3 run the quarter wave backwards.
    assign quad_p1 = top_p1[TOP_W-1 -: 2];
    assign idx_p1  = top_p1[TOP_W-3 -: LUT_AW];
    assign addr_p1 = quad_p1[0] ? ~idx_p1 : idx_p1;

    // ---- stage 2: synchronous ROM read ----
    logic              vld_p2;
    logic [TOP_W-1:0]  top_p2;
    logic [1:0]        sel_p2;
    logic [COEF_W-1:0] mag_p2;
    logic [DATA_W-1:0] wave_p2;

    // Stage-2 valid; cleared by reset so an in-flight sample is dropped.
    always_ff @(posedge clk) begin
        if (rst)
            vld_p2 <= 1'b0;
        else
            vld_p2 <= vld_p1;
    end

    // Registered ROM output plus the phase bits the waveform math needs.
    always_ff @(posedge clk) begin
        if (vld_p1) begin
            mag_p2 <= lut_rom[addr_p1];
            top_p2 <= top_p1;
            sel_p2 <= sel_p1;
        end
    end

    assign wave_p2 = wave_sample(sel_p2, top_p2, mag_p2);

    // ---- stage 3: output register, start pulse and overrun flag ----
    // A busy SPI master drops the sample and latches the sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            start   <= 1'b0;
            sample  <= 10'd512;
            data    <= DATA_RST;
            overrun <= 1'b0;
        end else begin
            start <= vld_p2 && !spi_busy;
            if (vld_p2 && spi_busy)
                overrun <= 1'b1;
            if (vld_p2 && !spi_busy) begin
                sample <= wave_p2;
                data   <= {DAC_CTRL, wave_p2, 2'b00};
            end
        end
    end

endmodule
